// File: rtl/riscv_dbg_pkg.sv
// rtl/riscv_dbg_pkg.sv - shared command, state and halt-cause encodings for the run controller
package riscv_dbg_pkg;

  typedef enum logic [1:0] {
    OP_RUN    = 2'd0,
    OP_HALT   = 2'd1,
    OP_STEP   = 2'd2,
    OP_SET_BP = 2'd3
  } cmd_op_e;

  typedef enum logic [1:0] {
    RS_HALTED = 2'd0,
    RS_RUN    = 2'd1,
    RS_STEP   = 2'd2
  } run_state_e;

  typedef enum logic [1:0] {
    HC_NONE = 2'd0,
    HC_CMD  = 2'd1,
    HC_STEP = 2'd2,
    HC_BP   = 2'd3
  } halt_cause_e;

  localparam logic [1:0] CMD_RUN    = 2'd0;
  localparam logic [1:0] CMD_HALT   = 2'd1;
  localparam logic [1:0] CMD_STEP   = 2'd2;
  localparam logic [1:0] CMD_SET_BP = 2'd3;

  localparam logic [1:0] CAUSE_NONE = 2'd0;
  localparam logic [1:0] CAUSE_CMD  = 2'd1;
  localparam logic [1:0] CAUSE_STEP = 2'd2;
  localparam logic [1:0] CAUSE_BP   = 2'd3;

  localparam logic [1:0] S_HALTED = 2'd0;
  localparam logic [1:0] S_RUN    = 2'd1;
  localparam logic [1:0] S_STEP   = 2'd2;

endpackage

// File: rtl/riscv_bp_match.sv
// rtl/riscv_bp_match.sv - breakpoint slot registers with lowest-index-wins PC match
module riscv_bp_match
  import riscv_dbg_pkg::*;
#(
  parameter int NUM_BP = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic [2:0]  wr_idx,
  input  logic [29:0] wr_addr,
  input  logic        wr_bp_en,
  input  logic [29:0] pc_word,
  output logic        hit,
  output logic [2:0]  hit_idx
);

  logic [29:0]       bp_addr [NUM_BP];
  logic [NUM_BP-1:0] bp_en;

  // Slot write port; the caller guarantees wr_idx is in range when wr_en is high
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_BP; i++) begin
        bp_addr[i] <= '0;
      end
      bp_en <= '0;
    end else if (wr_en) begin
      for (int i = 0; i < NUM_BP; i++) begin
        if (wr_idx == 3'(i)) begin
          bp_addr[i] <= wr_addr;
          bp_en[i]   <= wr_bp_en;
        end
      end
    end
  end

  // Scan from the top slot down so the lowest matching index is the one left standing
  always_comb begin
    hit     = 1'b0;
    hit_idx = 3'd0;
    for (int i = NUM_BP - 1; i >= 0; i--) begin
      if (bp_en[i] && (pc_word == bp_addr[i])) begin
        hit     = 1'b1;
        hit_idx = 3'(i);
      end
    end
  end

endmodule

// File: rtl/riscv_run_ctrl.sv
// rtl/riscv_run_ctrl.sv - run/halt/step/breakpoint controller gating the core's architectural update
module riscv_run_ctrl
  import riscv_dbg_pkg::*;
#(
  parameter int NUM_BP       = 4,
  parameter int CNT_W        = 32,
  parameter int START_HALTED = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [2:0]       cmd_idx,
  input  logic [31:0]      cmd_data,
  input  logic [31:0]      pc_i,
  output logic             core_en,
  output logic             halted,
  output logic [1:0]       halt_cause,
  output logic [2:0]       bp_hit_idx,
  output logic             cmd_err,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt
);

  localparam logic [1:0] RESET_STATE = (START_HALTED != 0) ? S_HALTED : S_RUN;

  logic [1:0] state;
  logic       skip;
  logic       accept;
  logic       idx_ok;
  logic       bp_wr;
  logic       bp_hit;
  logic [2:0] bp_idx;
  logic       bp_fire;
  logic [2:0] unused_bits;

  assign unused_bits = {cmd_data[1], pc_i[1:0]};

  assign cmd_ready = (state != S_STEP);
  assign accept    = cmd_valid & cmd_ready;
  assign idx_ok    = (int'(cmd_idx) < NUM_BP);
  assign bp_wr     = accept && (cmd_op == CMD_SET_BP) && idx_ok;
  assign bp_fire   = (state == S_RUN) && bp_hit && !skip;
  assign halted    = (state == S_HALTED);

  riscv_bp_match #(
    .NUM_BP (NUM_BP)
  ) u_bp_match (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (bp_wr),
    .wr_idx   (cmd_idx),
    .wr_addr  (cmd_data[31:2]),
    .wr_bp_en (cmd_data[0]),
    .pc_word  (pc_i[31:2]),
    .hit      (bp_hit),
    .hit_idx  (bp_idx)
  );

  // A breakpoint hit suppresses retirement in the same cycle so the instruction never executes
  always_comb begin
    core_en = 1'b0;
    case (state)
      S_RUN:   core_en = !bp_fire;
      S_STEP:  core_en = 1'b1;
      default: core_en = 1'b0;
    endcase
  end

  // Run-state machine, skip flag and error pulse; breakpoint outranks a same-cycle HALT
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= RESET_STATE;
      skip       <= 1'b0;
      halt_cause <= CAUSE_NONE;
      bp_hit_idx <= 3'd0;
      cmd_err    <= 1'b0;
    end else begin
      cmd_err <= 1'b0;
      skip    <= 1'b0;
      if (accept && (cmd_op == CMD_SET_BP) && !idx_ok) begin
        cmd_err <= 1'b1;
      end
      if ((state == S_RUN) && accept && ((cmd_op == CMD_RUN) || (cmd_op == CMD_STEP))) begin
        cmd_err <= 1'b1;
      end
      case (state)
        S_HALTED: begin
          if (accept && (cmd_op == CMD_RUN)) begin
            state <= S_RUN;
            skip  <= 1'b1;
          end else if (accept && (cmd_op == CMD_STEP)) begin
            state <= S_STEP;
          end
        end
        S_RUN: begin
          if (bp_fire) begin
            state      <= S_HALTED;
            halt_cause <= CAUSE_BP;
            bp_hit_idx <= bp_idx;
          end else if (accept && (cmd_op == CMD_HALT)) begin
            state      <= S_HALTED;
            halt_cause <= CAUSE_CMD;
          end
        end
        S_STEP: begin
          state      <= S_HALTED;
          halt_cause <= CAUSE_STEP;
        end
        default: state <= S_HALTED;
      endcase
    end
  end

  // Free-running cycle counter and retired-instruction counter, both wrapping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_cnt   <= '0;
      instret_cnt <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + 1'b1;
      if (core_en) begin
        instret_cnt <= instret_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_riscv_run_ctrl.sv
// tb/tb_riscv_run_ctrl.sv - directed self-checking bench for riscv_run_ctrl
module tb_riscv_run_ctrl;

  logic        clk;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [2:0]  cmd_idx;
  logic [31:0] cmd_data;
  logic [31:0] pc;
  logic        core_en;
  logic        halted;
  logic [1:0]  halt_cause;
  logic [2:0]  bp_hit_idx;
  logic        cmd_err;
  logic [31:0] cycle_cnt;
  logic [31:0] instret_cnt;

  logic        pc_load;
  logic [31:0] pc_load_val;

  int passed;
  int total;

  riscv_run_ctrl #(
    .NUM_BP       (4),
    .CNT_W        (32),
    .START_HALTED (1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_op      (cmd_op),
    .cmd_idx     (cmd_idx),
    .cmd_data    (cmd_data),
    .pc_i        (pc),
    .core_en     (core_en),
    .halted      (halted),
    .halt_cause  (halt_cause),
    .bp_hit_idx  (bp_hit_idx),
    .cmd_err     (cmd_err),
    .cycle_cnt   (cycle_cnt),
    .instret_cnt (instret_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Minimal core: PC advances by one word whenever the controller lets an instruction retire
  always @(posedge clk or posedge rst) begin
    if (rst) pc <= 32'h0;
    else if (pc_load) pc <= pc_load_val;
    else if (core_en) pc <= pc + 32'd4;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] op, input logic [2:0] idx, input logic [31:0] data);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_idx   = idx;
    cmd_data  = data;
    tick();
    cmd_valid = 1'b0;
    cmd_op    = 2'd0;
    cmd_idx   = 3'd0;
    cmd_data  = 32'h0;
  endtask

  task automatic load_pc(input logic [31:0] v);
    pc_load     = 1'b1;
    pc_load_val = v;
    tick();
    pc_load = 1'b0;
  endtask

  initial begin
    logic [31:0] target;
    passed      = 0;
    total       = 0;
    rst         = 1'b1;
    cmd_valid   = 1'b0;
    cmd_op      = 2'd0;
    cmd_idx     = 3'd0;
    cmd_data    = 32'h0;
    pc_load     = 1'b0;
    pc_load_val = 32'h0;

    // Reset values and 10 idle clocks in HALTED
    tick();
    check("rst_halted", {31'b0, halted}, 32'd1);
    check("rst_cycle", cycle_cnt, 32'd0);
    rst = 1'b0;
    repeat (10) tick();
    check("idle_core_en", {31'b0, core_en}, 32'd0);
    check("idle_halted", {31'b0, halted}, 32'd1);
    check("idle_cause", {30'b0, halt_cause}, 32'd0);
    check("idle_instret", instret_cnt, 32'd0);
    check("idle_cycle", cycle_cnt, 32'd10);
    check("idle_ready", {31'b0, cmd_ready}, 32'd1);

    // Three single steps, two clocks each
    for (int s = 0; s < 3; s++) begin
      send(2'd2, 3'd0, 32'h0);
      check("step_core_en", {31'b0, core_en}, 32'd1);
      check("step_ready", {31'b0, cmd_ready}, 32'd0);
      tick();
      check("step_done_en", {31'b0, core_en}, 32'd0);
      check("step_cause", {30'b0, halt_cause}, 32'd2);
    end
    check("step_instret", instret_cnt, 32'd3);
    check("step_pc", pc, 32'd12);
    check("step_cycle", cycle_cnt, 32'd16);

    // Breakpoint at 0x10, run from PC 0: 0,4,8,0xC retire, 0x10 does not
    send(2'd3, 3'd0, 32'h0000_0011);
    check("setbp_err", {31'b0, cmd_err}, 32'd0);
    load_pc(32'h0);
    send(2'd0, 3'd0, 32'h0);
    check("run_started", {31'b0, halted}, 32'd0);
    repeat (4) tick();
    check("bp_pc", pc, 32'h10);
    check("bp_core_en", {31'b0, core_en}, 32'd0);
    tick();
    check("bp_halted", {31'b0, halted}, 32'd1);
    check("bp_cause", {30'b0, halt_cause}, 32'd3);
    check("bp_idx", {29'b0, bp_hit_idx}, 32'd0);
    check("bp_instret", instret_cnt, 32'd7);
    check("bp_pc_hold", pc, 32'h10);

    // Resume off the breakpoint: skip lets 0x10 retire once
    send(2'd0, 3'd0, 32'h0);
    check("skip_core_en", {31'b0, core_en}, 32'd1);
    tick();
    check("skip_pc", pc, 32'h14);
    check("skip_running", {31'b0, halted}, 32'd0);
    check("skip_instret", instret_cnt, 32'd8);
    load_pc(32'h10);
    check("rehit_core_en", {31'b0, core_en}, 32'd0);
    tick();
    check("rehit_cause", {30'b0, halt_cause}, 32'd3);
    check("rehit_instret", instret_cnt, 32'd9);

    // HALT arriving in the same cycle as a hit on slot 2
    send(2'd3, 3'd2, 32'h0000_0041);
    load_pc(32'h38);
    send(2'd0, 3'd0, 32'h0);
    tick();
    tick();
    check("bp2_pc", pc, 32'h40);
    check("bp2_core_en", {31'b0, core_en}, 32'd0);
    send(2'd1, 3'd0, 32'h0);
    check("bp2_halted", {31'b0, halted}, 32'd1);
    check("bp2_cause", {30'b0, halt_cause}, 32'd3);
    check("bp2_idx", {29'b0, bp_hit_idx}, 32'd2);
    check("bp2_err", {31'b0, cmd_err}, 32'd0);

    // Plain HALT while running: accepting-cycle instruction still retires
    send(2'd0, 3'd0, 32'h0);
    tick();
    check("halt_pre_pc", pc, 32'h44);
    send(2'd1, 3'd0, 32'h0);
    check("halt_pc", pc, 32'h48);
    check("halt_cause_cmd", {30'b0, halt_cause}, 32'd1);
    check("halt_halted", {31'b0, halted}, 32'd1);

    // HALT while halted is a silent no-op
    send(2'd1, 3'd0, 32'h0);
    check("halt_noop_err", {31'b0, cmd_err}, 32'd0);
    check("halt_noop_pc", pc, 32'h48);

    // Illegal commands while running
    send(2'd0, 3'd0, 32'h0);
    send(2'd0, 3'd0, 32'h0);
    check("run_in_run_err", {31'b0, cmd_err}, 32'd1);
    check("run_in_run_state", {31'b0, halted}, 32'd0);
    tick();
    check("err_pulse_end", {31'b0, cmd_err}, 32'd0);
    target = pc + 32'd8;
    send(2'd3, 3'd5, target | 32'h1);
    check("bad_idx_err", {31'b0, cmd_err}, 32'd1);
    tick();
    check("bad_idx_pc", pc, target);
    check("bad_idx_no_write", {31'b0, core_en}, 32'd1);

    // Asynchronous reset mid-run clears counters immediately
    #2;
    rst = 1'b1;
    #1;
    check("arst_cycle", cycle_cnt, 32'd0);
    check("arst_instret", instret_cnt, 32'd0);
    check("arst_halted", {31'b0, halted}, 32'd1);
    check("arst_core_en", {31'b0, core_en}, 32'd0);
    tick();
    rst = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
